// File: rtl/arm_mem_pkg.sv
// Shared address map and STATUS bit layout for the core's data-side memory responder.
package arm_mem_pkg;

  localparam logic [31:0] LEDS_ADR   = 32'hFFFF_FF00;
  localparam logic [31:0] CYCLES_ADR = 32'hFFFF_FF04;
  localparam logic [31:0] TXQ_ADR    = 32'hFFFF_FF08;
  localparam logic [31:0] STATUS_ADR = 32'hFFFF_FF0C;
  // RAM lives in the first 256 bytes; any of these bits set is outside it
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_FF00;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_OVF   = 2;

  // Word-granular match: byte-offset bits never take part in decode
  function automatic logic word_sel(input logic [31:0] adr, input logic [31:0] base);
    return ((adr ^ base) & 32'hFFFF_FFFC) == 32'd0;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Circular byte FIFO with a registered head output that holds its last value when empty.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     rej_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             pop, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign pop     = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ok = push_i && (!full_o || pop);
  assign rej_o   = push_i && !push_ok;
  assign count_o = cnt_q;
  assign dout_o  = dout_q;

  always_comb begin
    rd_d   = rd_q + PW'(pop);
    wr_d   = wr_q + PW'(push_ok);
    cnt_d  = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    dout_d = dout_q;
    // New head may be the byte being written this very edge
    if (cnt_d != '0) begin
      if (push_ok && (rd_d == wr_q)) dout_d = din_i;
      else                           dout_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-port responder: word RAM plus LED, cycle counter, TX FIFO and status registers.
module data_mem_mmio
  import arm_mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int TXDEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] Leds,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TXDEPTH) + 1;

  logic [31:0]   ram_q [DEPTH];
  logic [31:0]   leds_q, leds_d, cyc_q, cyc_d;
  logic          ovf_q, ovf_d;
  logic [5:0]    ram_idx;
  logic          sel_ram, sel_leds, sel_cyc, sel_txq, sel_stat;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_empty, tx_rej;

  assign ram_idx  = DataAdr[7:2];
  assign sel_ram  = ((DataAdr & RAM_MASK) == 32'd0) && ({26'd0, ram_idx} < 32'(DEPTH));
  assign sel_leds = word_sel(DataAdr, LEDS_ADR);
  assign sel_cyc  = word_sel(DataAdr, CYCLES_ADR);
  assign sel_txq  = word_sel(DataAdr, TXQ_ADR);
  assign sel_stat = word_sel(DataAdr, STATUS_ADR);

  tx_fifo #(.DEPTH(TXDEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (MemWrite && sel_txq),
    .din_i   (WriteData[7:0]),
    .pop_i   (TxReady),
    .dout_o  (TxData),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt),
    .rej_o   (tx_rej)
  );

  assign TxValid = !tx_empty;
  assign Leds    = leds_q;

  always_comb begin
    leds_d = (MemWrite && sel_leds) ? WriteData : leds_q;
    cyc_d  = (MemWrite && sel_cyc) ? WriteData : cyc_q + 32'd1;
    // A rejected push outranks a same-cycle clear
    ovf_d  = (ovf_q && !(MemWrite && sel_stat)) || tx_rej;
  end

  always_comb begin
    ReadData = 32'd0;
    if (sel_ram) begin
      ReadData = ram_q[ram_idx[AW-1:0]];
    end else if (sel_leds) begin
      ReadData = leds_q;
    end else if (sel_cyc) begin
      ReadData = cyc_q;
    end else if (sel_txq) begin
      ReadData = 32'(tx_cnt);
    end else if (sel_stat) begin
      ReadData[ST_FULL]  = tx_full;
      ReadData[ST_EMPTY] = tx_empty;
      ReadData[ST_OVF]   = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (MemWrite && sel_ram) ram_q[ram_idx[AW-1:0]] <= WriteData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q <= 32'd0;
      cyc_q  <= 32'd0;
      ovf_q  <= 1'b0;
    end else begin
      leds_q <= leds_d;
      cyc_q  <= cyc_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule
